gpio_emu: RTL and testbench

//   Memory-mapped 24x24-bit multiplier peripheral behind the emulated SYKOM bus (saddress/srd/swr).

---
 rtl/gpio_emu.sv | 133 +++++++++++++
 tb/tb_gpio_emu.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/gpio_emu.sv
// ============================================================================
// Module   : gpio_emu
// Brief    : SYKOM-bus 24x24 multiplier peripheral (W, popcount L, status B)
//            with GPIO output; optional GPIO input latch via GPIOEMU_GPIO_LATCH_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gpio_emu #(
    parameter logic [31:0] ADDR_A1 = 32'h2C8,
    parameter logic [31:0] ADDR_A2 = 32'h2D0,
    parameter logic [31:0] ADDR_W  = 32'h2D8,
    parameter logic [31:0] ADDR_L  = 32'h2E0,
    parameter logic [31:0] ADDR_B  = 32'h2E8
) (
    input  logic        n_reset,
    input  logic [31:0] saddress,
    input  logic        srd,
    input  logic        swr,
    input  logic [31:0] sdata_in,
    output logic [31:0] sdata_out,
    input  logic [31:0] gpio_in,
    input  logic        gpio_latch,
    output logic [31:0] gpio_out,
    output logic [31:0] gpio_in_s_insp,
    input  logic        clk
);

    logic [31:0] r_a1;
    logic [31:0] r_a2;
    logic [31:0] r_w;
    logic [5:0]  r_l;
    logic [31:0] r_b;
    logic        r_pend;

    logic        w_wr_a1;
    logic        w_wr_a2;
    logic        w_e1;
    logic        w_e2;
    logic [47:0] w_p;
    logic [5:0]  w_pop;
    logic [31:0] w_w;
    logic [5:0]  w_l;
    logic [31:0] w_b;
    logic [31:0] w_rdata;

    assign w_wr_a1 = swr && (saddress == ADDR_A1);
    assign w_wr_a2 = swr && (saddress == ADDR_A2);

    always_comb begin
        w_e1  = |r_a1[31:24];
        w_e2  = |r_a2[31:24];
        w_p   = 48'(r_a1[23:0]) * 48'(r_a2[23:0]);
        w_pop = 6'd0;
        for (int i = 0; i < 32; i++) begin
            w_pop = w_pop + 6'(w_p[i]);
        end
        w_w = 32'd0;
        w_l = 6'd0;
        w_b = 32'd0;
        if (w_e1 || w_e2) begin
            w_b = {27'd0, 1'b0, w_e2, w_e1, 2'b00};
        end else begin
            w_w = w_p[31:0];
            w_l = w_pop;
            w_b = {27'd0, 1'b1, 2'b00, 1'b0, |w_p[47:32]};
        end
    end

    always_comb begin
        w_rdata = 32'd0;
        if (saddress == ADDR_W) begin
            w_rdata = r_w;
        end else if (saddress == ADDR_L) begin
            w_rdata = {26'd0, r_l};
        end else if (saddress == ADDR_B) begin
            w_rdata = r_b;
        end
    end

    // Results update one edge after an operand write, from the stored operands.
    always_ff @(posedge clk or posedge n_reset) begin
        if (n_reset) begin
            r_a1      <= 32'd0;
            r_a2      <= 32'd0;
            r_w       <= 32'd0;
            r_l       <= 6'd0;
            r_b       <= 32'd0;
            r_pend    <= 1'b0;
            sdata_out <= 32'd0;
            gpio_out  <= 32'd0;
        end else begin
            r_pend <= w_wr_a1 || w_wr_a2;
            if (w_wr_a1) begin
                r_a1 <= sdata_in;
            end
            if (w_wr_a2) begin
                r_a2 <= sdata_in;
            end
            if (r_pend) begin
                r_w <= w_w;
                r_l <= w_l;
                r_b <= w_b;
            end
            if (srd) begin
                sdata_out <= w_rdata;
            end
            gpio_out <= r_w;
        end
    end

`ifdef GPIOEMU_GPIO_LATCH_EN
    logic [31:0] r_gpio_in_s;

    always_ff @(posedge clk or posedge n_reset) begin
        if (n_reset) begin
            r_gpio_in_s <= 32'd0;
        end else if (gpio_latch) begin
            r_gpio_in_s <= gpio_in;
        end
    end

    assign gpio_in_s_insp = r_gpio_in_s;
`else
    logic w_unused_gpio;

    assign w_unused_gpio  = ^{gpio_in, gpio_latch};
    assign gpio_in_s_insp = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gpio_emu.sv
// ============================================================================
// Module   : tb_gpio_emu
// Brief    : Self-checking bench for gpio_emu: directed cases, random operand
//            pairs against an arithmetic reference, reset and GPIO latch checks.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_gpio_emu;

    localparam logic [31:0] C_ADDR_A1 = 32'h2C8;
    localparam logic [31:0] C_ADDR_A2 = 32'h2D0;
    localparam logic [31:0] C_ADDR_W  = 32'h2D8;
    localparam logic [31:0] C_ADDR_L  = 32'h2E0;
    localparam logic [31:0] C_ADDR_B  = 32'h2E8;
    localparam int          C_NRAND   = 3000;

    logic        clk;
    logic        n_reset;
    logic [31:0] saddress;
    logic        srd;
    logic        swr;
    logic [31:0] sdata_in;
    logic [31:0] sdata_out;
    logic [31:0] gpio_in;
    logic        gpio_latch;
    logic [31:0] gpio_out;
    logic [31:0] gpio_in_s_insp;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_a1 = 32'd0;
    logic [31:0] m_a2 = 32'd0;

    gpio_emu dut (
        .n_reset        (n_reset),
        .saddress       (saddress),
        .srd            (srd),
        .swr            (swr),
        .sdata_in       (sdata_in),
        .sdata_out      (sdata_out),
        .gpio_in        (gpio_in),
        .gpio_latch     (gpio_latch),
        .gpio_out       (gpio_out),
        .gpio_in_s_insp (gpio_in_s_insp),
        .clk            (clk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: the result of multiplying the stored operands, from the rules alone.
    task automatic model(output logic [31:0] ew, output logic [31:0] el, output logic [31:0] eb);
        longint unsigned p;
        bit e1, e2;
        e1 = (m_a1 >= 32'h0100_0000);
        e2 = (m_a2 >= 32'h0100_0000);
        ew = 0; el = 0; eb = 0;
        if (e1 || e2) begin
            eb = (e1 ? 32'd4 : 32'd0) + (e2 ? 32'd8 : 32'd0);
        end else begin
            p  = longint'(m_a1) * longint'(m_a2);
            ew = 32'(p % 64'h1_0000_0000);
            for (longint unsigned v = ew; v != 0; v = v / 2) el += 32'(v % 2);
            eb = 32'd16 + ((p >= 64'h1_0000_0000) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        saddress = addr; sdata_in = data; swr = 1'b1;
        @(posedge clk); #1;
        swr = 1'b0;
        if (addr == C_ADDR_A1) m_a1 = data;
        if (addr == C_ADDR_A2) m_a2 = data;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        saddress = addr; srd = 1'b1;
        @(posedge clk); #1;
        srd = 1'b0;
        data = sdata_out;
    endtask

    task automatic check_results(input string tag, input logic [31:0] ew,
                                 input logic [31:0] el, input logic [31:0] eb);
        logic [31:0] d;
        repeat (2) @(posedge clk);
        #1;
        rd(C_ADDR_W, d); check({tag, ".W"}, d, ew);
        rd(C_ADDR_L, d); check({tag, ".L"}, d, el);
        rd(C_ADDR_B, d); check({tag, ".B"}, d, eb);
        check({tag, ".gpio_out"}, gpio_out, ew);
    endtask

    initial begin
        logic [31:0] d, ew, el, eb;
        int          op;
        n_reset = 1'b1; saddress = 32'd0; srd = 1'b0; swr = 1'b0;
        sdata_in = 32'd0; gpio_in = 32'd0; gpio_latch = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.sdata_out", sdata_out, 32'd0);
        check("reset.gpio_out", gpio_out, 32'd0);
        check("reset.insp", gpio_in_s_insp, 32'd0);
        n_reset = 1'b0;
        check_results("reset", 32'd0, 32'd0, 32'd0);

        wr(C_ADDR_A1, 32'd2); wr(C_ADDR_A2, 32'd3);
        check_results("2x3", 32'd6, 32'd2, 32'h10);
        rd(C_ADDR_A1, d); check("rd_a1_zero", d, 32'd0);
        rd(32'h100, d);   check("rd_unmapped_zero", d, 32'd0);

        wr(C_ADDR_A1, 32'h80_0000); wr(C_ADDR_A2, 32'h80_0001);
        check_results("ovf", 32'h0080_0000, 32'd1, 32'h11);

        wr(C_ADDR_A1, 32'h0100_0000);
        check_results("a1_oor", 32'd0, 32'd0, 32'h04);
        wr(C_ADDR_A1, 32'd0);
        check_results("a1_clear", 32'd0, 32'd0, 32'h10);

        wr(C_ADDR_A2, 32'h0100_0000);
        check_results("a2_oor", 32'd0, 32'd0, 32'h08);
        wr(C_ADDR_A1, 32'hA); wr(C_ADDR_A2, 32'hB);
        check_results("10x11", 32'h6E, 32'd5, 32'h10);

        // Read data persists after the strobe drops; writes elsewhere are ignored.
        rd(C_ADDR_W, d);
        wr(C_ADDR_W, 32'hDEAD_BEEF);
        repeat (2) @(posedge clk);
        #1;
        check("hold.sdata_out", sdata_out, 32'h6E);
        check_results("ignored_wr", 32'h6E, 32'd5, 32'h10);

        for (int i = 0; i < C_NRAND; i++) begin
            op = int'($urandom_range(0, 2));
            if (op != 1) wr(C_ADDR_A1, ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 32'hFF_FFFF));
            if (op != 0) wr(C_ADDR_A2, ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 32'hFF_FFFF));
            model(ew, el, eb);
            check_results("rand", ew, el, eb);
        end

        wr(C_ADDR_A1, 32'd5); wr(C_ADDR_A2, 32'd7);
        check_results("pre_rst", 32'd35, 32'd3, 32'h10);
        wr(C_ADDR_A1, 32'd9);
        n_reset = 1'b1;
        #1;
        check("mid_rst.sdata_out", sdata_out, 32'd0);
        check("mid_rst.gpio_out", gpio_out, 32'd0);
        @(posedge clk); #1;
        n_reset = 1'b0;
        m_a1 = 32'd0; m_a2 = 32'd0;
        check_results("post_rst", 32'd0, 32'd0, 32'd0);

        gpio_in = 32'hA5A5_A5A5; gpio_latch = 1'b1;
        @(posedge clk); #1;
        gpio_latch = 1'b0; gpio_in = 32'h0;
        @(posedge clk); #1;
`ifdef GPIOEMU_GPIO_LATCH_EN
        check("gpio_latch", gpio_in_s_insp, 32'hA5A5_A5A5);
`else
        check("gpio_latch", gpio_in_s_insp, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
